uart_cmd_tx: RTL and testbench
==============================

UART_CMD_TX -- requirements
Module: uart_cmd_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every serialised byte and of the DATA, OP_A and OP_B inputs.
REQ-002 Parameter ADDR_WIDTH, default 4: register-file address width.
REQ-003 Parameter ALU_FUN_WIDTH, default 4: ALU function code width.
REQ-004 Parameter PRESCALE_WIDTH, default 6: width of the bit-period input.
REQ-005 One clock; reset is synchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-006 CLK  in  1  sole clock; all state changes on rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 CMD_VALID  in  1  command request.
REQ-009 CMD_READY  out  1  block can accept a command; high only in IDLE.
REQ-010 CMD_TYPE  in  2  command select: 00 WRITE, 01 READ, 10 ALU_OP, 11 ALU_NOP.
REQ-011 ADDR  in  ADDR_WIDTH  register address.
REQ-012 DATA  in  DATA_WIDTH  write data.
REQ-013 OP_A, OP_B  in  DATA_WIDTH each  ALU operands.
REQ-014 ALU_FUN  in  ALU_FUN_WIDTH  ALU function code.
REQ-015 PAR_EN  in  1  parity bit present when 1.
REQ-016 PAR_TYP  in  1  0 even, 1 odd.
REQ-017 PRESCALE  in  PRESCALE_WIDTH  CLK cycles per serial bit.
REQ-018 TX_OUT  out  1  serial line; idle high.
REQ-019 BUSY  out  1  high from the cycle after acceptance until the last stop bit ends.
REQ-020 DONE  out  1  one-cycle pulse in the cycle after the last stop bit ends.

Function
REQ-021 Acceptance: CMD_VALID & CMD_READY at a rising edge latches all command, parity and PRESCALE inputs; later input changes have no effect until the next acceptance.
REQ-022 CMD_VALID while BUSY is ignored; there is no queueing.
REQ-023 Byte sequences, sent in order:
- WRITE: 0xAA, {0,ADDR}, DATA (3 frames).
- READ: 0xBB, {0,ADDR} (2 frames).
- ALU_OP: 0xCC, OP_A, OP_B, {0,ALU_FUN} (4 frames).
- ALU_NOP: 0xDD, {0,ALU_FUN} (2 frames).
- {0,x} means zero-extended to DATA_WIDTH.
REQ-024 Frame format:
- start bit 0;
- DATA_WIDTH data bits, LSB first;
- parity bit if PAR_EN (even: XOR of data bits; odd: its inverse);
- one stop bit 1.
REQ-025 Each serial bit shall be held for PRESCALE CLK cycles; PRESCALE=0 shall be treated as 1.
REQ-026 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE->START on acceptance.
- START->DATA after one bit period.
- DATA->PARITY after DATA_WIDTH bits if PAR_EN, otherwise DATA->STOP.
- PARITY->STOP after one bit period.
- STOP->START if frames remain; STOP->IDLE after the last frame.
REQ-027 Frames are back-to-back: the next start bit begins in the cycle after the previous stop bit ends, with no idle gap.
REQ-028 Latency: the start bit of frame 0 appears on TX_OUT in the first cycle after the acceptance edge.
REQ-029 Total BUSY duration = frames × (10 + PAR_EN) × max(PRESCALE,1) cycles.
REQ-030 Parity is computed from the byte being sent, per frame.
REQ-031 TX_OUT is registered and glitch-free; it is 1 in IDLE.
REQ-032 CMD_READY returns high in the same cycle DONE pulses; a new command can be accepted at that edge.
REQ-033 Bit-period counter and bit index wrap to 0 at each bit/frame boundary; no state is carried between commands.

Reset
REQ-034 While RST=1 at a rising edge, and in the cycle that follows:
- FSM=IDLE, TX_OUT=1, CMD_READY=1, BUSY=0, DONE=0;
- all counters and latched fields are cleared.
REQ-035 Reset asserted mid-frame aborts the command immediately; no partial stop bit and no DONE pulse are produced.

Verification
REQ-036 WRITE ADDR=4 DATA=0xA6, PAR_EN=1 even, PRESCALE=8 -> TX_OUT serialises 0xAA/p0, 0x04/p1, 0xA6/p0; 264 BUSY cycles; DONE pulses once.
REQ-037 ALU_OP A=0x35 B=0x88 FUN=2, PAR_EN=1 even -> frames 0xCC/p0, 0x35/p0, 0x88/p0, 0x02/p1, back-to-back with no gaps.
REQ-038 READ ADDR=4, PAR_EN=1 odd -> 0xBB/p1, 0x04/p0; with PAR_EN=0 each frame is 10 bits and BUSY lasts 20×PRESCALE cycles.
REQ-039 CMD_VALID held high through an ALU_NOP FUN=3 -> exactly one command sent (0xDD, 0x03); the second command is accepted in the DONE cycle.
REQ-040 RST pulsed during data bit 3 of frame 1 -> TX_OUT=1, BUSY=0, CMD_READY=1 in the cycle after reset; no DONE pulse.
REQ-041 PRESCALE=0 -> each bit lasts 1 cycle; PRESCALE changed mid-command -> bit timing unchanged.

Source files
------------

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: serialises a register-file / ALU command as a burst of UART frames.
//
// A command is accepted when cmd_valid_i and cmd_ready_o are both high at a rising edge.
// Every command, parity and prescale input is latched at that edge, so later changes to
// those inputs have no effect. The command is then sent as a fixed sequence of
// back-to-back frames:
//   WRITE   : 0xAA, {0,addr}, data
//   READ    : 0xBB, {0,addr}
//   ALU_OP  : 0xCC, op_a, op_b, {0,alu_fun}
//   ALU_NOP : 0xDD, {0,alu_fun}
// Each frame is: start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit,
// and one stop bit (1). Every bit lasts max(prescale, 1) clock cycles.
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_i        synchronous, active-high reset
//   cmd_valid_i  command request
//   cmd_ready_o  high only while idle; a command may be accepted
//   cmd_type_i   00 WRITE, 01 READ, 10 ALU_OP, 11 ALU_NOP
//   addr_i       register address
//   data_i       write data
//   op_a_i       ALU operand A
//   op_b_i       ALU operand B
//   alu_fun_i    ALU function code
//   par_en_i     parity bit present when 1
//   par_typ_i    0 even, 1 odd
//   prescale_i   clock cycles per serial bit (0 treated as 1)
//   tx_out_o     registered serial line, idle high
//   busy_o       high from the cycle after acceptance until the last stop bit ends
//   done_o       one-cycle pulse in the cycle after the last stop bit ends
module uart_cmd_tx #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned ALU_FUN_WIDTH  = 4,
   parameter int unsigned PRESCALE_WIDTH = 6
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [1:0]                cmd_type_i,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic [DATA_WIDTH-1:0]     data_i,
   input  logic [DATA_WIDTH-1:0]     op_a_i,
   input  logic [DATA_WIDTH-1:0]     op_b_i,
   input  logic [ALU_FUN_WIDTH-1:0]  alu_fun_i,
   input  logic                      par_en_i,
   input  logic                      par_typ_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   output logic                      tx_out_o,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [1:0] CmdWrite  = 2'b00;
   localparam logic [1:0] CmdRead   = 2'b01;
   localparam logic [1:0] CmdAluOp  = 2'b10;
   localparam logic [1:0] CmdAluNop = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e                    state_q, state_d;
   logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
   logic [PRESCALE_WIDTH-1:0] period_q, period_d;
   logic [BitW-1:0]           bit_q, bit_d;
   logic [1:0]                frame_q, frame_d;
   logic                      done_q, done_d;
   logic                      tx_q, tx_d;

   logic [1:0]                type_q, type_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic [DATA_WIDTH-1:0]     op_a_q, op_a_d;
   logic [DATA_WIDTH-1:0]     op_b_q, op_b_d;
   logic [ALU_FUN_WIDTH-1:0]  fun_q, fun_d;
   logic                      par_en_q, par_en_d;
   logic                      par_typ_q, par_typ_d;

   logic                      bit_end;
   logic [DATA_WIDTH-1:0]     byte_d;

   // Byte carried by frame idx of a command. Frame 0 depends only on the type, which lets
   // the acceptance cycle use the live cmd_type_i before the operand fields are latched.
   function automatic logic [DATA_WIDTH-1:0] frame_byte(
      input logic [1:0]               typ,
      input logic [1:0]               idx,
      input logic [ADDR_WIDTH-1:0]    addr,
      input logic [DATA_WIDTH-1:0]    data,
      input logic [DATA_WIDTH-1:0]    op_a,
      input logic [DATA_WIDTH-1:0]    op_b,
      input logic [ALU_FUN_WIDTH-1:0] fun
   );
      logic [DATA_WIDTH-1:0] b;
      b = '0;
      if (idx == 2'd0) begin
         case (typ)
            CmdWrite: b = DATA_WIDTH'(8'hAA);
            CmdRead:  b = DATA_WIDTH'(8'hBB);
            CmdAluOp: b = DATA_WIDTH'(8'hCC);
            default:  b = DATA_WIDTH'(8'hDD);
         endcase
      end else begin
         case (typ)
            CmdWrite: b = (idx == 2'd1) ? DATA_WIDTH'(addr) : data;
            CmdRead:  b = DATA_WIDTH'(addr);
            CmdAluOp: begin
               case (idx)
                  2'd1:    b = op_a;
                  2'd2:    b = op_b;
                  default: b = DATA_WIDTH'(fun);
               endcase
            end
            default:  b = DATA_WIDTH'(fun);
         endcase
      end
      return b;
   endfunction

   function automatic logic [1:0] last_frame(input logic [1:0] typ);
      logic [1:0] n;
      case (typ)
         CmdWrite:  n = 2'd2;
         CmdRead:   n = 2'd1;
         CmdAluOp:  n = 2'd3;
         CmdAluNop: n = 2'd1;
         default:   n = 2'd1;
      endcase
      return n;
   endfunction

   assign bit_end = (cnt_q == period_q - PRESCALE_WIDTH'(1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      bit_d     = bit_q;
      frame_d   = frame_q;
      done_d    = 1'b0;
      type_d    = type_q;
      addr_d    = addr_q;
      data_d    = data_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      fun_d     = fun_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;

      case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               state_d   = StStart;
               cnt_d     = '0;
               bit_d     = '0;
               frame_d   = '0;
               period_d  = (prescale_i == '0) ? PRESCALE_WIDTH'(1) : prescale_i;
               type_d    = cmd_type_i;
               addr_d    = addr_i;
               data_d    = data_i;
               op_a_d    = op_a_i;
               op_b_d    = op_b_i;
               fun_d     = alu_fun_i;
               par_en_d  = par_en_i;
               par_typ_d = par_typ_i;
            end
         end
         StStart: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + PRESCALE_WIDTH'(1);
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == BitW'(DATA_WIDTH - 1)) begin
                  bit_d   = '0;
                  state_d = par_en_q ? StParity : StStop;
               end else begin
                  bit_d = bit_q + BitW'(1);
               end
            end else begin
               cnt_d = cnt_q + PRESCALE_WIDTH'(1);
            end
         end
         StParity: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = StStop;
            end else begin
               cnt_d = cnt_q + PRESCALE_WIDTH'(1);
            end
         end
         StStop: begin
            if (bit_end) begin
               cnt_d = '0;
               if (frame_q == last_frame(type_q)) begin
                  frame_d = '0;
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  frame_d = frame_q + 2'd1;
                  state_d = StStart;
               end
            end else begin
               cnt_d = cnt_q + PRESCALE_WIDTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // The line value is derived from the next state so that tx_out_o is a plain register
   // and the start bit appears in the first cycle after acceptance.
   always_comb begin
      byte_d = frame_byte(type_d, frame_d, addr_q, data_q, op_a_q, op_b_q, fun_q);
      tx_d   = 1'b1;
      case (state_d)
         StIdle:   tx_d = 1'b1;
         StStart:  tx_d = 1'b0;
         StData:   tx_d = byte_d[bit_d];
         StParity: tx_d = (^byte_d) ^ par_typ_d;
         StStop:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         period_q  <= '0;
         bit_q     <= '0;
         frame_q   <= '0;
         done_q    <= 1'b0;
         tx_q      <= 1'b1;
         type_q    <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         fun_q     <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         bit_q     <= bit_d;
         frame_q   <= frame_d;
         done_q    <= done_d;
         tx_q      <= tx_d;
         type_q    <= type_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         fun_q     <= fun_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
      end
   end

   assign cmd_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign done_o      = done_q;
   assign tx_out_o    = tx_q;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Directed bench for uart_cmd_tx: hand-computed frame bytes and parity bits per command.
module tb_uart_cmd_tx;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic [1:0] cmd_type_i;
   logic [3:0] addr_i;
   logic [7:0] data_i;
   logic [7:0] op_a_i;
   logic [7:0] op_b_i;
   logic [3:0] alu_fun_i;
   logic       par_en_i;
   logic       par_typ_i;
   logic [5:0] prescale_i;
   logic       tx_out_o;
   logic       busy_o;
   logic       done_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   uart_cmd_tx #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (4),
      .ALU_FUN_WIDTH  (4),
      .PRESCALE_WIDTH (6)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_type_i  (cmd_type_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .op_a_i      (op_a_i),
      .op_b_i      (op_b_i),
      .alu_fun_i   (alu_fun_i),
      .par_en_i    (par_en_i),
      .par_typ_i   (par_typ_i),
      .prescale_i  (prescale_i),
      .tx_out_o    (tx_out_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] data,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                        input logic pen, input logic ptyp, input logic [5:0] pre);
      cmd_type_i  = typ;
      addr_i      = addr;
      data_i      = data;
      op_a_i      = a;
      op_b_i      = b;
      alu_fun_i   = fun;
      par_en_i    = pen;
      par_typ_i   = ptyp;
      prescale_i  = pre;
      cmd_valid_i = 1'b1;
   endtask

   // Called at a negedge with the command already driven; the next posedge accepts it.
   // per is the effective bit period; par holds the expected parity bit of each frame.
   task automatic run_check(input string name, input int nfr, input logic pen, input int per,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [3:0] par, input bit hold);
      logic [7:0]  bytes[4];
      logic [10:0] got[4];
      logic [10:0] exp;
      int          nbits, total, unstable, busy_cnt, done_cnt, f, bpos;
      bytes    = '{b0, b1, b2, b3};
      got      = '{11'd0, 11'd0, 11'd0, 11'd0};
      nbits    = pen ? 11 : 10;
      total    = nfr * nbits * per;
      unstable = 0;
      busy_cnt = 0;
      done_cnt = 0;
      @(posedge clk_i);
      for (int i = 0; i < total; i++) begin
         @(negedge clk_i);
         if (i == 0 && !hold) begin
            // Disturb every input; the latched command must be unaffected.
            cmd_valid_i = 1'b0;
            prescale_i  = prescale_i + 6'd5;
            data_i      = ~data_i;
            addr_i      = ~addr_i;
            op_a_i      = op_a_i ^ 8'hFF;
            op_b_i      = op_b_i ^ 8'h0F;
            alu_fun_i   = alu_fun_i ^ 4'hF;
            par_typ_i   = ~par_typ_i;
            par_en_i    = ~par_en_i;
            cmd_type_i  = cmd_type_i + 2'd1;
         end
         f    = i / (nbits * per);
         bpos = (i % (nbits * per)) / per;
         if (i % per == 0) got[f][bpos] = tx_out_o;
         else if (got[f][bpos] !== tx_out_o) unstable++;
         if (busy_o) busy_cnt++;
         if (done_o) done_cnt++;
      end
      for (int k = 0; k < nfr; k++) begin
         exp = pen ? {1'b1, par[k], bytes[k], 1'b0} : {2'b01, bytes[k], 1'b0};
         check($sformatf("%s_frame%0d", name, k), 32'(got[k]), 32'(exp));
      end
      check({name, "_unstable"}, unstable, 0);
      check({name, "_busy_cycles"}, busy_cnt, total);
      check({name, "_early_done"}, done_cnt, 0);
      @(negedge clk_i);
      check({name, "_done_pulse"}, 32'(done_o), 1);
      check({name, "_busy_end"}, 32'(busy_o), 0);
      check({name, "_tx_idle"}, 32'(tx_out_o), 1);
      check({name, "_ready_in_done"}, 32'(cmd_ready_o), 1);
      if (!hold) begin
         @(negedge clk_i);
         check({name, "_done_one_cycle"}, 32'(done_o), 0);
      end
   endtask

   initial begin
      int done_cnt, busy_cnt, tx_bad;
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_type_i  = 2'b00;
      addr_i      = '0;
      data_i      = '0;
      op_a_i      = '0;
      op_b_i      = '0;
      alu_fun_i   = '0;
      par_en_i    = 1'b0;
      par_typ_i   = 1'b0;
      prescale_i  = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_tx", 32'(tx_out_o), 1);
      check("rst_ready", 32'(cmd_ready_o), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done", 32'(done_o), 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // WRITE addr 4 data 0xA6, even parity, 8 cycles/bit -> 264 busy cycles.
      drive(2'b00, 4'h4, 8'hA6, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 6'd8);
      run_check("write", 3, 1'b1, 8, 8'hAA, 8'h04, 8'hA6, 8'h00, 4'b0010, 1'b0);

      // ALU_OP A=0x35 B=0x88 FUN=2, even parity.
      drive(2'b10, 4'h0, 8'h00, 8'h35, 8'h88, 4'h2, 1'b1, 1'b0, 6'd2);
      run_check("aluop", 4, 1'b1, 2, 8'hCC, 8'h35, 8'h88, 8'h02, 4'b1000, 1'b0);

      // READ addr 4, odd parity.
      drive(2'b01, 4'h4, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 6'd3);
      run_check("read_odd", 2, 1'b1, 3, 8'hBB, 8'h04, 8'h00, 8'h00, 4'b0001, 1'b0);

      // READ addr 4, no parity -> 10-bit frames, 20 x 5 busy cycles.
      drive(2'b01, 4'h4, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 6'd5);
      run_check("read_nopar", 2, 1'b0, 5, 8'hBB, 8'h04, 8'h00, 8'h00, 4'b0000, 1'b0);

      // ALU_NOP FUN=3 with valid held high and prescale 0: second copy accepted in DONE cycle.
      drive(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 6'd0);
      run_check("nop_hold", 2, 1'b0, 1, 8'hDD, 8'h03, 8'h00, 8'h00, 4'b0000, 1'b1);
      run_check("nop_second", 2, 1'b0, 1, 8'hDD, 8'h03, 8'h00, 8'h00, 4'b0000, 1'b0);

      // Reset during data bit 3 of frame 1 (frame = 44 cycles, bit 3 at positions 60..63).
      drive(2'b00, 4'h4, 8'hA6, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 6'd4);
      @(posedge clk_i);
      for (int k = 0; k < 62; k++) begin
         @(negedge clk_i);
         cmd_valid_i = 1'b0;
      end
      check("abort_busy_before", 32'(busy_o), 1);
      check("abort_tx_before", 32'(tx_out_o), 0);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("abort_tx", 32'(tx_out_o), 1);
      check("abort_busy", 32'(busy_o), 0);
      check("abort_ready", 32'(cmd_ready_o), 1);
      check("abort_done", 32'(done_o), 0);
      rst_i    = 1'b0;
      done_cnt = 0;
      busy_cnt = 0;
      tx_bad   = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk_i);
         if (done_o) done_cnt++;
         if (busy_o) busy_cnt++;
         if (tx_out_o !== 1'b1) tx_bad++;
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_stays_idle", busy_cnt, 0);
      check("abort_line_high", tx_bad, 0);

      // Recovery after abort: READ addr 5, no parity, 1 cycle/bit.
      drive(2'b01, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 6'd1);
      run_check("read_after_rst", 2, 1'b0, 1, 8'hBB, 8'h05, 8'h00, 8'h00, 4'b0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
